// File: rtl/layer_done_responder.sv
// layer_done_responder: per-layer tile completion accounting for the layer
// sequencing handshake. Tracks the runLayer code from global_controller,
// counts tileDone pulses and emits one conv/pool/fc status pulse when the
// active layer's quota is met.
// Optional feature: define LAYER_WATCHDOG_EN to build the RUN-state
// watchdog that drives timeoutErr; otherwise timeoutErr is tied low.
module layer_done_responder #(
    parameter int CONV_TILES  = 16,
    parameter int POOL_TILES  = 8,
    parameter int FC_TILES    = 4,
    parameter int CNT_W       = 8,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [3:0]       runLayer,
    input  logic             tileDone,
    output logic             convStatus,
    output logic             poolStatus,
    output logic             fcStatus,
    output logic             layerStart,
    output logic             layerBusy,
    output logic [CNT_W-1:0] tileCount,
    output logic             layerErr,
    output logic             timeoutErr
);

    typedef enum logic [2:0] {IDLE, ARM, RUN, DONE, HOLD} state_t;

    state_t           state;
    logic [3:0]       curLayer;
    logic             startQ, convQ, poolQ, fcQ;
    logic             isConv, isPool, isFc;
    logic [CNT_W-1:0] quotaM1;
    logic             newLegal;
    logic             retarget;
    logic             strayTile;

    // Layer type and quota follow the latched layer, not the live input.
    always_comb begin
        isConv = 1'b0;
        isPool = 1'b0;
        isFc   = 1'b0;
        case (curLayer)
            4'd1, 4'd3, 4'd5, 4'd6, 4'd7: isConv = 1'b1;
            4'd2, 4'd4, 4'd8:             isPool = 1'b1;
            4'd9, 4'd10, 4'd11:           isFc   = 1'b1;
            default: ;
        endcase
        quotaM1 = CNT_W'(CONV_TILES - 1);
        if (isPool) quotaM1 = CNT_W'(POOL_TILES - 1);
        if (isFc)   quotaM1 = CNT_W'(FC_TILES - 1);
    end

    // IDLE keeps curLayer at 0, so a code change in IDLE, RUN or HOLD is
    // the same event: 0 parks, legal re-arms, illegal parks and flags.
    assign newLegal  = (runLayer != 4'd0) && (runLayer <= 4'd11);
    assign retarget  = (state == IDLE || state == RUN || state == HOLD) &&
                       (runLayer != curLayer);
    assign strayTile = tileDone && (state == IDLE || state == DONE || state == HOLD);

    // Sequencer: state, layer latch, tile counter, pulses and sticky error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            curLayer  <= 4'd0;
            tileCount <= '0;
            layerBusy <= 1'b0;
            layerErr  <= 1'b0;
            startQ    <= 1'b0;
            convQ     <= 1'b0;
            poolQ     <= 1'b0;
            fcQ       <= 1'b0;
        end else if (ena) begin
            startQ <= 1'b0;
            convQ  <= 1'b0;
            poolQ  <= 1'b0;
            fcQ    <= 1'b0;
            if (strayTile) layerErr <= 1'b1;
            if (retarget) begin
                // A change mid-RUN aborts silently; the pending tile is dropped.
                layerBusy <= 1'b0;
                if (runLayer == 4'd0) begin
                    state    <= IDLE;
                    curLayer <= 4'd0;
                end else if (newLegal) begin
                    state     <= ARM;
                    curLayer  <= runLayer;
                    tileCount <= '0;
                    startQ    <= 1'b1;
                end else begin
                    state    <= IDLE;
                    curLayer <= 4'd0;
                    layerErr <= 1'b1;
                end
            end else begin
                case (state)
                    ARM: begin
                        state     <= RUN;
                        layerBusy <= 1'b1;
                    end
                    RUN: begin
                        if (tileDone) begin
                            if (tileCount == quotaM1) begin
                                // Final tile: count stays at quota-1 (no wrap).
                                state     <= DONE;
                                layerBusy <= 1'b0;
                                convQ     <= isConv;
                                poolQ     <= isPool;
                                fcQ       <= isFc;
                            end else begin
                                tileCount <= tileCount + 1'b1;
                            end
                        end
                    end
                    DONE:    state <= HOLD;
                    default: ;
                endcase
            end
        end
    end

    // Pulse registers freeze with ena low; gating keeps them quiet meanwhile
    // and lets a frozen pulse appear exactly once when ena returns.
    assign layerStart = startQ & ena;
    assign convStatus = convQ & ena;
    assign poolStatus = poolQ & ena;
    assign fcStatus   = fcQ & ena;

`ifdef LAYER_WATCHDOG_EN
    localparam int WD_W = $clog2(WDOG_CYCLES + 1);
    logic [WD_W-1:0] wdogCnt;

    // Watchdog: cycles in RUN since entry or the last tile; flag only, the
    // controller owns recovery.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdogCnt    <= '0;
            timeoutErr <= 1'b0;
        end else if (ena) begin
            if (state == ARM) begin
                wdogCnt <= '0;
            end else if (state == RUN) begin
                if (tileDone) begin
                    wdogCnt <= '0;
                end else if (wdogCnt != WD_W'(WDOG_CYCLES)) begin
                    wdogCnt <= wdogCnt + 1'b1;
                    if (wdogCnt == WD_W'(WDOG_CYCLES - 1)) timeoutErr <= 1'b1;
                end
            end
        end
    end
`else
    assign timeoutErr = 1'b0;
`endif

endmodule

// File: tb/tb_layer_done_responder.sv
// Bench for layer_done_responder: directed layer walks with a status-pulse
// scoreboard (expected type and cycle queued at stimulus time, popped by a
// monitor) plus direct checks of counters, flags and reset behaviour.
module tb_layer_done_responder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ena = 1'b1;
    logic [3:0] runLayer = 4'd0;
    logic       tileDone = 1'b0;
    logic       convStatus, poolStatus, fcStatus, layerStart, layerBusy;
    logic [7:0] tileCount;
    logic       layerErr, timeoutErr;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int expType[$];
    int expCyc[$];
    int gotType, nHigh, eT, eC;

    // Hand-written layer table: quota and type (1 conv, 2 pool, 3 fc).
    localparam int QUOTA [0:11] = '{0, 16, 8, 16, 8, 16, 16, 16, 8, 4, 4, 4};
    localparam int LTYPE [0:11] = '{0, 1, 2, 1, 2, 1, 1, 1, 2, 3, 3, 3};

    layer_done_responder #(
        .CONV_TILES(16), .POOL_TILES(8), .FC_TILES(4), .CNT_W(8), .WDOG_CYCLES(20)
    ) dut (
        .clk(clk), .rst(rst), .ena(ena), .runLayer(runLayer), .tileDone(tileDone),
        .convStatus(convStatus), .poolStatus(poolStatus), .fcStatus(fcStatus),
        .layerStart(layerStart), .layerBusy(layerBusy), .tileCount(tileCount),
        .layerErr(layerErr), .timeoutErr(timeoutErr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // n back-to-back tiles; typ != 0 queues the status pulse expected one
    // cycle after the last tile is sampled.
    task automatic pulses(input int n, input int typ);
        for (int i = 0; i < n; i++) begin
            tileDone = 1'b1;
            if (i == n - 1 && typ != 0) begin
                expType.push_back(typ);
                expCyc.push_back(cyc + 1);
            end
            step(1);
        end
        tileDone = 1'b0;
    endtask

    task automatic startLayer(input int code);
        runLayer = 4'(code);
        step(1);
        check("layerStart_arm", int'(layerStart), 1);
        check("tileCount_arm", int'(tileCount), 0);
        step(1);
        check("layerBusy_run", int'(layerBusy), 1);
        check("layerStart_run", int'(layerStart), 0);
    endtask

    // Monitor: every status pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        #1;
        nHigh = int'(convStatus) + int'(poolStatus) + int'(fcStatus);
        if (nHigh != 0) begin
            gotType = convStatus ? 1 : (poolStatus ? 2 : 3);
            if (nHigh > 1) begin
                check("status_onehot", nHigh, 1);
            end else if (expType.size() == 0) begin
                check("unexpected_status", gotType, 0);
            end else begin
                eT = expType.pop_front();
                eC = expCyc.pop_front();
                check("status_type", gotType, eT);
                check("status_cycle", cyc, eC);
            end
        end
    end

    initial begin
        // Reset state.
        step(2);
        check("rst_busy", int'(layerBusy), 0);
        check("rst_count", int'(tileCount), 0);
        check("rst_start", int'(layerStart), 0);
        check("rst_err", int'(layerErr), 0);
        check("rst_tmo", int'(timeoutErr), 0);
        rst = 1'b1;
        step(1);

        // Full AlexNet walk, layers 1..11.
        for (int l = 1; l <= 11; l++) begin
            startLayer(l);
            pulses(QUOTA[l], LTYPE[l]);
            check("done_busy", int'(layerBusy), 0);
            check("done_count", int'(tileCount), QUOTA[l] - 1);
            step(1);
        end
        runLayer = 4'd0;
        step(2);
        check("walk_err", int'(layerErr), 0);

        // Abort conv1 after 10 tiles; the coincident tile must be dropped.
        startLayer(1);
        pulses(10, 0);
        check("abort_count10", int'(tileCount), 10);
        runLayer = 4'd2;
        tileDone = 1'b1;
        step(1);
        tileDone = 1'b0;
        check("abort_start", int'(layerStart), 1);
        check("abort_count0", int'(tileCount), 0);
        step(1);
        check("abort_busy", int'(layerBusy), 1);
        pulses(8, 2);
        step(1);
        runLayer = 4'd0;
        step(2);

        // Stray tile in IDLE, reset clear, illegal code.
        check("stray_pre", int'(layerErr), 0);
        tileDone = 1'b1;
        step(1);
        tileDone = 1'b0;
        check("stray_err", int'(layerErr), 1);
        rst = 1'b0;
        #1;
        check("stray_rstclr", int'(layerErr), 0);
        step(1);
        rst = 1'b1;
        runLayer = 4'd13;
        step(1);
        check("illegal_err", int'(layerErr), 1);
        check("illegal_start", int'(layerStart), 0);
        step(1);
        check("illegal_busy", int'(layerBusy), 0);
        check("illegal_start2", int'(layerStart), 0);
        runLayer = 4'd0;
        rst = 1'b0;
        step(1);
        rst = 1'b1;
        step(1);
        check("illegal_clr", int'(layerErr), 0);

        // Enable freeze mid-conv3.
        startLayer(5);
        pulses(6, 0);
        check("ena_count_pre", int'(tileCount), 6);
        ena = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tileDone = (i % 2) == 0;
            step(1);
        end
        check("ena_count_hold", int'(tileCount), 6);
        check("ena_busy_hold", int'(layerBusy), 1);
        ena = 1'b1;
        tileDone = 1'b0;
        pulses(10, 1);
        check("ena_count_done", int'(tileCount), 15);
        check("ena_err", int'(layerErr), 0);
        step(1);
        runLayer = 4'd0;
        step(2);

        // Watchdog in fc6 with no tiles: RUN entered at the edge before
        // startLayer returns; the flag lands 20 RUN cycles later.
        startLayer(9);
        step(19);
        check("wdog_19", int'(timeoutErr), 0);
        step(1);
`ifdef LAYER_WATCHDOG_EN
        check("wdog_20", int'(timeoutErr), 1);
`else
        check("wdog_off", int'(timeoutErr), 0);
`endif
        check("wdog_busy", int'(layerBusy), 1);

        // Async reset mid-RUN: immediate clear, no status afterwards.
        pulses(3, 0);
        check("arst_count_pre", int'(tileCount), 3);
        #2 rst = 1'b0;
        #1;
        check("arst_busy", int'(layerBusy), 0);
        check("arst_count", int'(tileCount), 0);
        check("arst_tmo", int'(timeoutErr), 0);
        check("arst_status", int'(convStatus | poolStatus | fcStatus), 0);
        runLayer = 4'd0;
        tileDone = 1'b1;
        step(1);
        tileDone = 1'b0;
        rst = 1'b1;
        step(4);
        check("arst_idle_busy", int'(layerBusy), 0);
        check("arst_idle_err", int'(layerErr), 0);

        step(2);
        check("pending_status", expType.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/layer_done_responder.md
# layer_done_responder

Completion responder for the layer sequencing handshake. It watches the `runLayer` code issued by `global_controller` and counts `tileDone` pulses from the compute engines. When the active layer's tile quota is reached, it returns exactly one single-cycle `convStatus`, `poolStatus` or `fcStatus` pulse. It sits between the conv/pool/fc engines and `global_controller`, and replaces the hand-driven status stimulus with per-layer completion accounting.

## Interface
- `CONV_TILES`, default 16: `tileDone` pulses that complete any conv layer.
- `POOL_TILES`, default 8: pulses that complete any pool layer.
- `FC_TILES`, default 4: pulses that complete any fc layer.
- `CNT_W`, default 8: tile counter width; every tile parameter is ≥1 and <2^CNT_W.
- `WDOG_CYCLES`, default 1024: watchdog limit (used only with the macro).
- Clocking and reset (already decided): one clock `clk`; reset `rst` is asynchronous, active-low.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous active-low reset.
- `ena`  in  1  block enable; low freezes all state.
- `runLayer`  in  4  layer code from `global_controller`.
  - 0 idle; 1 conv1; 2 pool1; 3 conv2; 4 pool2; 5 conv3; 6 conv4; 7 conv5; 8 pool5; 9 fc6; 10 fc7; 11 fc8.
  - 12–15 are illegal.
- `tileDone`  in  1  one pulse per finished tile from the active engine.
- `convStatus` / `poolStatus` / `fcStatus`  out  1 each  one-cycle completion pulses.
- `layerStart`  out  1  one-cycle pulse when a new layer is armed.
- `layerBusy`  out  1  high while counting tiles.
- `tileCount`  out  CNT_W  tiles completed in the current layer.
- `layerErr`  out  1  sticky; set on an illegal code or on `tileDone` outside RUN.
- `timeoutErr`  out  1  sticky watchdog flag (see Configuration).

## Operation
- `runLayer` is registered internally as `curLayer`. Layer type is decoded from `curLayer`:
  - conv: 1, 3, 5, 6, 7.
  - pool: 2, 4, 8.
  - fc: 9, 10, 11.
- The tile quota is selected by layer type.
- States: IDLE, ARM, RUN, DONE, HOLD.
- IDLE:
  - A legal nonzero `runLayer` → ARM.
  - A code of 12–15 sets `layerErr` and stays in IDLE.
- ARM (1 cycle): latch `curLayer`, clear `tileCount`, pulse `layerStart` → RUN.
- RUN:
  - `layerBusy` is high.
  - Each `tileDone` increments `tileCount`.
  - A `tileDone` at `tileCount == quota-1` → DONE.
- DONE (1 cycle): pulse exactly one status output by layer type → HOLD.
- HOLD:
  - Waits for `runLayer != curLayer`.
  - New legal nonzero code → ARM.
  - 0 → IDLE.
  - Illegal code → IDLE and sets `layerErr`.
- A `runLayer` change during RUN aborts the layer: no status pulse, → ARM (or IDLE if the new code is 0).
- `tileDone` in IDLE, HOLD or DONE sets `layerErr` and is otherwise ignored.
- When `ena` is low, state, counters and `curLayer` hold, `tileDone` is ignored, and all pulse outputs are 0. Sticky flags hold.
- `layerErr` and `timeoutErr` clear only on reset.

## Timing
- Reset values: state IDLE, `curLayer` 0, `tileCount` 0. All outputs are 0.
- Reset is asynchronous and may be asserted mid-RUN. The in-flight layer is discarded and no status pulse is emitted.
- Latencies:
  - `runLayer` change at edge N → `layerStart` high during cycle N+1 → `layerBusy` from N+2.
  - Final `tileDone` sampled at edge M → status pulse high during cycle M+1 only. `layerBusy` drops at M+1.
- Quota of 1: the first `tileDone` in RUN completes the layer.
- `tileDone` coincident with a `runLayer` change in RUN: the abort wins and the tile is not counted.
- Status pulses are mutually exclusive and never back-to-back. At least ARM plus one RUN cycle separates any two pulses.
- `tileCount` saturates at quota-1 and never wraps.

## Configuration
- `LAYER_WATCHDOG_EN` defined:
  - A counter clears on entry to RUN and on each `tileDone`, and increments every enabled RUN cycle.
  - Reaching `WDOG_CYCLES` sets `timeoutErr`. The state is unchanged, so the controller decides recovery.
- `LAYER_WATCHDOG_EN` undefined: no watchdog logic, and `timeoutErr` is tied to 0.

## Test plan
- Reset then full AlexNet walk: step `runLayer` 1→11 and give each layer its quota of pulses (16/8/16/8/16/16/16/8/4/4/4). Expect, in order, the pulses conv, pool, conv, pool, conv, conv, conv, pool, fc, fc, fc. Each is one cycle wide, one cycle after the last `tileDone`.
- Abort: `runLayer`=1 with 10 pulses, then `runLayer`=2. Expect no `convStatus`, `layerStart` again, `tileCount` back to 0, and `poolStatus` after 8 pulses.
- Stray and illegal input: `tileDone` in IDLE sets `layerErr`. `runLayer`=13 sets `layerErr` and keeps the block in IDLE. `rst` low clears `layerErr`.
- Enable freeze: `ena`=0 for 5 cycles mid-conv3 with `tileDone` toggling. Expect `tileCount` unchanged, and completion after exactly 16 enabled pulses.
- Watchdog (macro defined, `WDOG_CYCLES`=20): `runLayer`=9 with no `tileDone`. Expect `timeoutErr` set 20 cycles after entry to RUN. Macro undefined: `timeoutErr` stays 0.
- Async reset mid-RUN: drop `rst` between edges. Expect outputs 0 immediately, and no status pulse after release.
